cpu_mem_responder: RTL

Target end of the CPU data-memory bus. It accepts single-cycle `cpu_request` pulses from the execute stage and decodes the address into local data RAM, a peripheral window or unmapped space. It returns exactly one `cpu_valid` per accepted request, for reads and writes alike, and drives `cpu_mem_busy`. It sits between the CPU core and the on-chip data RAM / peripheral interconnect.

---
 rtl/cpu_mem_responder_pkg.sv | 32 +++
 rtl/cpu_mem_responder_if.sv | 37 +++
 rtl/cpu_mem_responder_data_ram.sv | 33 +++
 rtl/cpu_mem_responder.sv | 121 ++++++++++++
 4 files changed

// File: rtl/cpu_mem_responder_pkg.sv
// Shared bus definitions for the CPU data-memory responder: state encoding,
// region decode constants and the bus-error exception cause code.
package cpu_mem_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAM_RESP,
    ST_PERIPH_WAIT,
    ST_PERIPH_RESP,
    ST_ERR_RESP
  } state_e;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_PERIPH,
    REG_UNMAPPED
  } region_e;

  localparam logic [31:0] RAM_BASE         = 32'h0000_0000;
  localparam logic [31:0] PERIPH_BASE_DEF  = 32'hE000_0000;
  localparam logic [4:0]  CAUSE_BUS_ERROR  = 5'd5;

  // RAM wins over the peripheral window; everything else is unmapped.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input int unsigned ram_bits,
                                            input logic [31:0] periph_base);
    if ((addr >> (ram_bits + 2)) == (RAM_BASE >> (ram_bits + 2))) return REG_RAM;
    if (addr[31:28] == periph_base[31:28]) return REG_PERIPH;
    return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// CPU data-bus + peripheral-side signal bundle for cpu_mem_responder.
// slave = the responder; master = the CPU / peripheral environment around it.
interface cpu_mem_responder_if;
  logic        cpu_request;
  logic [31:0] cpu_address;
  logic        cpu_write;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_valid;
  logic        cpu_mem_busy;
  logic        periph_request;
  logic [31:0] periph_address;
  logic        periph_write;
  logic [3:0]  periph_wstrb;
  logic [31:0] periph_wdata;
  logic [31:0] periph_rdata;
  logic        periph_ready;
  logic        bus_error;
  logic [31:0] err_address;

  modport slave (
    input  cpu_request, cpu_address, cpu_write, cpu_wstrb, cpu_wdata,
           periph_rdata, periph_ready,
    output cpu_rdata, cpu_valid, cpu_mem_busy,
           periph_request, periph_address, periph_write, periph_wstrb, periph_wdata,
           bus_error, err_address
  );

  modport master (
    output cpu_request, cpu_address, cpu_write, cpu_wstrb, cpu_wdata,
           periph_rdata, periph_ready,
    input  cpu_rdata, cpu_valid, cpu_mem_busy,
           periph_request, periph_address, periph_write, periph_wstrb, periph_wdata,
           bus_error, err_address
  );
endinterface

// File: rtl/cpu_mem_responder_data_ram.sv
// Local data RAM (cpu_data_ram role): single-port, byte-enable, synchronous read,
// write-first, 2^ADDR_BITS x 32. No reset, so contents survive a responder reset.
module cpu_mem_responder_data_ram #(
  parameter int unsigned ADDR_BITS = 14
) (
  input  logic                 clock,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [3:0]           wstrb_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);
  logic [3:0][7:0] mem_q [2**ADDR_BITS];
  logic [3:0][7:0] rdata_q;
  logic [3:0][7:0] merged;

  // The read port returns the post-write word, giving write-first behaviour.
  always_comb begin
    merged = mem_q[addr_i];
    for (int i = 0; i < 4; i++)
      if (we_i && wstrb_i[i]) merged[i] = wdata_i[8*i +: 8];
  end

  always_ff @(posedge clock) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= merged;
      rdata_q <= merged;
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/cpu_mem_responder.sv
// Target end of the CPU data-memory bus: decodes to local RAM, peripheral window
// or unmapped space and returns one cpu_valid per accepted request.
// Optional peripheral wait timeout: define MEM_TIMEOUT_EN.
module cpu_mem_responder #(
  parameter int unsigned RAM_ADDR_BITS  = 14,
  parameter logic [31:0] PERIPH_BASE    = 32'hE000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clock,
  input  logic               reset,
  cpu_mem_responder_if.slave bus
);
  import cpu_mem_responder_pkg::*;

  state_e      state_q, state_d;
  region_e     region;
  logic        accept, in_wait, timeout;
  logic        preq_q;
  logic [31:0] paddr_q, pwdata_q, prdata_q, err_addr_q, ram_rdata;
  logic        pwrite_q;
  logic [3:0]  pwstrb_q;

  assign region  = decode_region(bus.cpu_address, RAM_ADDR_BITS, PERIPH_BASE);
  assign in_wait = (state_q == ST_PERIPH_WAIT);
  assign accept  = bus.cpu_request && !in_wait;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;

  // Fires in the wait cycle where the count would reach TIMEOUT_CYCLES.
  always_comb begin
    tmo_d   = '0;
    timeout = 1'b0;
    if (in_wait) begin
      tmo_d   = tmo_q + 8'd1;
      timeout = (({1'b0, tmo_q} + 9'd1) == 9'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d = ST_IDLE;
    if (in_wait) begin
      state_d = ST_PERIPH_WAIT;
      if (bus.periph_ready) state_d = ST_PERIPH_RESP;
      else if (timeout)     state_d = ST_ERR_RESP;
    end else if (accept) begin
      case (region)
        REG_RAM:    state_d = ST_RAM_RESP;
        REG_PERIPH: state_d = ST_PERIPH_WAIT;
        default:    state_d = ST_ERR_RESP;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      preq_q     <= 1'b0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwstrb_q   <= '0;
      pwdata_q   <= '0;
      prdata_q   <= '0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && region == REG_PERIPH) begin
        preq_q   <= 1'b1;
        paddr_q  <= bus.cpu_address;
        pwrite_q <= bus.cpu_write;
        pwstrb_q <= bus.cpu_wstrb;
        pwdata_q <= bus.cpu_wdata;
      end else if (in_wait && (bus.periph_ready || timeout)) begin
        preq_q <= 1'b0;
      end
      if (in_wait && bus.periph_ready) prdata_q <= bus.periph_rdata;
      if (accept && region == REG_UNMAPPED)              err_addr_q <= bus.cpu_address;
      else if (in_wait && !bus.periph_ready && timeout) err_addr_q <= paddr_q;
    end
  end

  cpu_mem_responder_data_ram #(.ADDR_BITS(RAM_ADDR_BITS)) u_ram (
    .clock   (clock),
    .en_i    (accept && region == REG_RAM),
    .we_i    (accept && region == REG_RAM && bus.cpu_write),
    .addr_i  (bus.cpu_address[RAM_ADDR_BITS+1:2]),
    .wstrb_i (bus.cpu_wstrb),
    .wdata_i (bus.cpu_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    bus.cpu_rdata = '0;
    case (state_q)
      ST_RAM_RESP:    bus.cpu_rdata = ram_rdata;
      ST_PERIPH_RESP: bus.cpu_rdata = prdata_q;
      default:        bus.cpu_rdata = '0;
    endcase
  end

  assign bus.cpu_valid      = (state_q == ST_RAM_RESP) || (state_q == ST_PERIPH_RESP) ||
                              (state_q == ST_ERR_RESP);
  assign bus.bus_error      = (state_q == ST_ERR_RESP);
  assign bus.cpu_mem_busy   = in_wait;
  assign bus.err_address    = err_addr_q;
  assign bus.periph_request = preq_q;
  assign bus.periph_address = paddr_q;
  assign bus.periph_write   = pwrite_q;
  assign bus.periph_wstrb   = pwstrb_q;
  assign bus.periph_wdata   = pwdata_q;
endmodule
